// File: rtl/wishbone_arbiter.sv
// Two-master / one-slave Wishbone B4 classic arbiter.
// Round-robin grant held for a whole cyc, combinational data/termination
// pass-through, and a watchdog that raises err on an unterminated access.
module wishbone_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // master 0 (instruction fetch)
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    // master 1 (load/store)
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    // slave
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t      state, state_nxt;
    logic        last;          // most recently granted master
    logic [7:0]  wd_cnt;
    logic        timeout_err;
    logic        gnt_stb;
    logic        term;

    assign term        = s_ack_i | s_err_i | s_rty_i;
    assign gnt_stb     = ((state == GRANT0) && m0_stb_i) || ((state == GRANT1) && m1_stb_i);
    // Only a live strobe can time out; a dropped stb clears the count anyway.
    assign timeout_err = gnt_stb && (wd_cnt == 8'(TIMEOUT - 1));

    // State register and round-robin history; last tracks every grant entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == GRANT0)      last <= 1'b0;
            else if (state_nxt == GRANT1) last <= 1'b1;
        end
    end

    // Next-state: never preempt; hand over directly when the other master waits.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GRANT0 : GRANT1;
                else if (m0_cyc_i)        state_nxt = GRANT0;
                else if (m1_cyc_i)        state_nxt = GRANT1;
            end
            GRANT0: begin
                if (!m0_cyc_i) state_nxt = m1_cyc_i ? GRANT1 : IDLE;
            end
            GRANT1: begin
                if (!m1_cyc_i) state_nxt = m0_cyc_i ? GRANT0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog: counts stalled strobe cycles, restarts on any termination,
    // stb low, grant change, or after it fires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt <= 8'd0;
        end else if ((state_nxt != state) || !gnt_stb || term || timeout_err) begin
            wd_cnt <= 8'd0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Output mux: slave sees the granted master, only the granted master sees returns.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        case (state)
            GRANT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | timeout_err;
                m0_rty_o = s_rty_i;
            end
            GRANT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | timeout_err;
                m1_rty_o = s_rty_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter with a small memory-like slave model:
// registered ack one cycle after stb, addresses >= 0x1000 never terminate.
module tb_wishbone_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i, s_err_i, s_rty_i;

    int n_chk  = 0;
    int n_fail = 0;

    wishbone_arbiter #(.TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    always #5 clk_i = ~clk_i;

    // Slave model: read data = adr ^ 0xCAFE0000, driven only while acking.
    logic        sl_ack;
    logic [31:0] sl_rd;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sl_ack <= 1'b0;
            sl_rd  <= '0;
        end else begin
            sl_ack <= s_cyc_o & s_stb_o & ~sl_ack & (s_adr_o < 32'h1000);
            sl_rd  <= s_adr_o ^ 32'hCAFE0000;
        end
    end
    assign s_ack_i = sl_ack;
    assign s_dat_i = sl_ack ? sl_rd : 32'hzzzz_zzzz;
    assign s_err_i = 1'b0;
    assign s_rty_i = 1'b0;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic bus_idle();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_i = 1'b1;
        mid();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        bus_idle();
        rst_i = 1'b1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10; m0_sel_i = 4'hF;
        next_cycle();
        next_cycle();
        mid();
        n_chk++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_slave_side: got cyc=%b adr=%h sel=%h, expected all 0", s_cyc_o, s_adr_o, s_sel_o);
        end
        n_chk++;
        if ({m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o, m1_ack_o, m1_err_o, m1_rty_o, m1_dat_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_master_side: got m0 ack/err/rty=%b%b%b dat=%h, expected all 0",
                     m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o);
        end
        bus_idle();
        rst_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_read();
        next_cycle();  // cycle 0
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF;
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL read_c0_idle: s_cyc_o=%b expected 0", s_cyc_o); end
        next_cycle();  // cycle 1
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h10 || s_we_o !== 1'b0) begin
            n_fail++; $display("FAIL read_c1_grant: cyc=%b adr=%h we=%b expected 1/00000010/0", s_cyc_o, s_adr_o, s_we_o);
        end
        n_chk++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL read_c1_noack: m0_ack=%b m1_ack=%b expected 0/0", m0_ack_o, m1_ack_o);
        end
        next_cycle();  // cycle 2
        mid();
        n_chk++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hCAFE0010) begin
            n_fail++; $display("FAIL read_c2_ack: ack=%b dat=%h expected 1/cafe0010", m0_ack_o, m0_dat_o);
        end
        n_chk++;
        if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL read_c2_m1_quiet: m1_ack=%b m1_dat=%h expected 0/0", m1_ack_o, m1_dat_o);
        end
        next_cycle();
        bus_idle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_tie();
        do_reset();
        next_cycle();  // c0
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h20; m0_sel_i = 4'hF;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h40; m1_sel_i = 4'hF;
        next_cycle();  // c1
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h20) begin
            n_fail++; $display("FAIL tie_first_m0: cyc=%b adr=%h expected 1/00000020", s_cyc_o, s_adr_o);
        end
        next_cycle();  // c2
        mid();
        n_chk++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hCAFE0020 || m1_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL tie_m0_ack: m0_ack=%b dat=%h m1_ack=%b expected 1/cafe0020/0", m0_ack_o, m0_dat_o, m1_ack_o);
        end
        next_cycle();  // c3: m0 releases
        m0_cyc_i = 0; m0_stb_i = 0;
        next_cycle();  // c4: direct handover
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h40) begin
            n_fail++; $display("FAIL tie_handover: cyc=%b adr=%h expected 1/00000040", s_cyc_o, s_adr_o);
        end
        next_cycle();  // c5
        mid();
        n_chk++;
        if (m1_ack_o !== 1'b1 || m1_dat_o !== 32'hCAFE0040 || m0_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL tie_m1_ack: m1_ack=%b dat=%h m0_dat=%h expected 1/cafe0040/0", m1_ack_o, m1_dat_o, m0_dat_o);
        end
        next_cycle();  // c6
        m1_cyc_i = 0; m1_stb_i = 0;
        next_cycle();  // c7: idle, second tie raised
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL tie_idle_gap: s_cyc_o=%b expected 0", s_cyc_o); end
        next_cycle();  // c8
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h20) begin
            n_fail++; $display("FAIL tie_round_robin: cyc=%b adr=%h expected 1/00000020", s_cyc_o, s_adr_o);
        end
        next_cycle();
        bus_idle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_no_preempt();
        int acks = 0;
        next_cycle();  // c0
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h100;
        m0_sel_i = 4'b0011; m0_dat_i = 32'hAAAA_5555;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 1) begin m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h200; m1_sel_i = 4'hF; end
            if (c == 3) m0_adr_i = 32'h104;
            if (c == 5) m0_adr_i = 32'h108;
            mid();
            n_chk++;
            if (s_sel_o !== 4'b0011 || s_dat_o !== 32'hAAAA_5555 || s_we_o !== 1'b1) begin
                n_fail++; $display("FAIL preempt_write_c%0d: sel=%b dat=%h we=%b expected 0011/aaaa5555/1", c, s_sel_o, s_dat_o, s_we_o);
            end
            n_chk++;
            if (m1_ack_o !== 1'b0 || m0_ack_o !== (c % 2 == 0)) begin
                n_fail++; $display("FAIL preempt_ack_c%0d: m0_ack=%b m1_ack=%b expected %0d/0", c, m0_ack_o, m1_ack_o, (c % 2 == 0));
            end
            if (m0_ack_o === 1'b1) acks++;
        end
        n_chk++;
        if (acks != 3) begin n_fail++; $display("FAIL preempt_ack_count: got %0d expected 3", acks); end
        next_cycle();  // c7: m0 releases
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        mid();
        n_chk++;
        if (m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL preempt_release: m1_ack=%b s_cyc=%b expected 0/0", m1_ack_o, s_cyc_o);
        end
        next_cycle();  // c8
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h200 || s_we_o !== 1'b0) begin
            n_fail++; $display("FAIL preempt_handover: cyc=%b adr=%h we=%b expected 1/00000200/0", s_cyc_o, s_adr_o, s_we_o);
        end
        next_cycle();  // c9
        mid();
        n_chk++;
        if (m1_ack_o !== 1'b1) begin n_fail++; $display("FAIL preempt_m1_ack: m1_ack=%b expected 1", m1_ack_o); end
        next_cycle();
        bus_idle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_timeout();
        int errs = 0;
        next_cycle();  // c0
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h8000_0000; m1_sel_i = 4'hF;
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            if (c == 17) begin m1_cyc_i = 0; m1_stb_i = 0; end
            mid();
            n_chk++;
            if (m1_err_o !== (c == 16) || m0_err_o !== 1'b0) begin
                n_fail++; $display("FAIL timeout_err_c%0d: m1_err=%b m0_err=%b expected %0d/0", c, m1_err_o, m0_err_o, (c == 16));
            end
            if (m1_err_o === 1'b1) errs++;
            if (c <= 16) begin
                n_chk++;
                if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== 32'h8000_0000) begin
                    n_fail++; $display("FAIL timeout_slave_c%0d: cyc=%b stb=%b adr=%h expected 1/1/80000000", c, s_cyc_o, s_stb_o, s_adr_o);
                end
            end
        end
        n_chk++;
        if (errs != 1) begin n_fail++; $display("FAIL timeout_pulse_count: got %0d expected 1", errs); end
        bus_idle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_async_reset();
        next_cycle();  // c0
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h8000_0000; m1_sel_i = 4'hF;
        next_cycle();  // c1
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h8000_0000) begin
            n_fail++; $display("FAIL areset_pre_grant: cyc=%b adr=%h expected 1/80000000", s_cyc_o, s_adr_o);
        end
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        bus_idle();
        #1;
        n_chk++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o} !== '0 ||
            {m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o, m1_ack_o, m1_err_o, m1_rty_o, m1_dat_o} !== '0) begin
            n_fail++; $display("FAIL areset_outputs: s_cyc=%b s_adr=%h m1_err=%b expected all 0", s_cyc_o, s_adr_o, m1_err_o);
        end
        mid();
        rst_i = 1'b0;
        next_cycle();
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL areset_idle: s_cyc_o=%b expected 0", s_cyc_o); end
        next_cycle();  // tie
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h20; m0_sel_i = 4'hF;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h40; m1_sel_i = 4'hF;
        next_cycle();
        mid();
        n_chk++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h20) begin
            n_fail++; $display("FAIL areset_tie_m0: cyc=%b adr=%h expected 1/00000020", s_cyc_o, s_adr_o);
        end
        next_cycle();
        bus_idle();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_no_preempt();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
